// File: rtl/div_iter_core.sv
// div_iter_core: iterative radix-2 restoring divider, one quotient bit per cycle.
// Divides operand magnitudes unsigned and hands the correction stage the unsigned
// quotient/remainder plus the latched sign flags, divisor two's complement and opcode.
// Optional build macro DIV_EARLY_EXIT_EN: finish at once when |dividend| < |divisor|.
module div_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [1:0]      op_div_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] q_o,
    output logic [XLEN-1:0] r_o,
    output logic            dividend32_o,
    output logic            divisor32_o,
    output logic [XLEN-1:0] divisor_2c_o,
    output logic [1:0]      op_div_o
);

    localparam int unsigned CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] qsh_q, rem_q, absb_q;
    logic [XLEN-1:0] q_q, r_q, div2c_q;
    logic            sign_a_q, sign_b_q;
    logic [1:0]      op_q;

    logic            sign_a, sign_b, b_zero, early, borrow, last_iter;
    logic [XLEN-1:0] abs_a, abs_b, rem_next, qsh_next;
    logic [XLEN:0]   shifted, trial;

    // Operand magnitudes and the short-path decisions taken in IDLE
    always_comb begin
        sign_a = op_div_i[0] & dividend_i[XLEN-1];
        sign_b = op_div_i[0] & divisor_i[XLEN-1];
        abs_a  = sign_a ? (~dividend_i + 1'b1) : dividend_i;
        abs_b  = sign_b ? (~divisor_i + 1'b1) : divisor_i;
        b_zero = (abs_b == '0);
`ifdef DIV_EARLY_EXIT_EN
        early  = !b_zero && (abs_a < abs_b);
`else
        early  = 1'b0;
`endif
    end

    // One restoring step; the full remainder is kept so a divisor above 2^(XLEN-1) still works
    always_comb begin
        shifted   = {rem_q, qsh_q[XLEN-1]};
        trial     = shifted - {1'b0, absb_q};
        borrow    = trial[XLEN];
        rem_next  = borrow ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        qsh_next  = {qsh_q[XLEN-2:0], ~borrow};
        last_iter = (cnt_q == CW'(XLEN - 1));
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start_i) state_d = (b_zero || early) ? StDone : StCalc;
            StCalc: if (last_iter) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_o = (state_q != StIdle);
        done_o = (state_q == StDone);
    end

    // Datapath: operand latch on accept, iteration in CALC, result capture on entry to DONE
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            qsh_q    <= '0;
            rem_q    <= '0;
            absb_q   <= '0;
            q_q      <= '0;
            r_q      <= '0;
            div2c_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            op_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_q     <= op_div_i;
                        qsh_q    <= abs_a;
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        absb_q   <= abs_b;
                        div2c_q  <= ~abs_b + 1'b1;
                        sign_a_q <= sign_a;
                        sign_b_q <= sign_b;
                        if (b_zero) begin
                            // Flags cleared so the correction stage passes these through untouched
                            q_q      <= '1;
                            r_q      <= dividend_i;
                            sign_a_q <= 1'b0;
                            sign_b_q <= 1'b0;
                        end else if (early) begin
                            q_q <= '0;
                            r_q <= abs_a;
                        end
                    end
                end
                StCalc: begin
                    qsh_q <= qsh_next;
                    rem_q <= rem_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        q_q <= qsh_next;
                        r_q <= rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q_o          = q_q;
    assign r_o          = r_q;
    assign dividend32_o = sign_a_q;
    assign divisor32_o  = sign_b_q;
    assign divisor_2c_o = div2c_q;
    assign op_div_o     = op_q;

endmodule

// File: tb/tb_div_iter_core.sv
// Scoreboard bench for div_iter_core: directed operations push expected results,
// a negedge monitor pops and compares whenever done_o is seen.
module tb_div_iter_core;

    localparam int unsigned XLEN = 32;
    // Busy cycles (accept+1 through the done cycle) on the full iterative path
    localparam int FullBusy = 33;
`ifdef DIV_EARLY_EXIT_EN
    localparam int EarlyBusy = 1;
`else
    localparam int EarlyBusy = 33;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [XLEN-1:0] dividend = '0;
    logic [XLEN-1:0] divisor = '0;
    logic [1:0]      op_div = '0;
    logic            busy, done, dividend32, divisor32;
    logic [XLEN-1:0] q, r, divisor_2c;
    logic [1:0]      op_div_out;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] c2;
        logic        sa;
        logic        sb;
        logic [1:0]  op;
        int          busy_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   busy_cnt = 0;
    logic post_done = 1'b0;

    div_iter_core #(.XLEN(XLEN)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .op_div_i     (op_div),
        .busy_o       (busy),
        .done_o       (done),
        .q_o          (q),
        .r_o          (r),
        .dividend32_o (dividend32),
        .divisor32_o  (divisor32),
        .divisor_2c_o (divisor_2c),
        .op_div_o     (op_div_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: counts busy cycles, and on done pops and compares the scoreboard entry
    always @(negedge clk) begin
        if (post_done) chk("busy_low_after_done", {31'd0, busy}, 32'd0);
        post_done = 1'b0;
        if (busy) busy_cnt = busy_cnt + 1;
        else      busy_cnt = 0;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done_o=1 expected no pending op");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("q_o", q, e.q);
                chk("r_o", r, e.r);
                chk("dividend32_o", {31'd0, dividend32}, {31'd0, e.sa});
                chk("divisor32_o", {31'd0, divisor32}, {31'd0, e.sb});
                chk("divisor_2c_o", divisor_2c, e.c2);
                chk("op_div_o", {30'd0, op_div_out}, {30'd0, e.op});
                chk("busy_cycles", busy_cnt, e.busy_cycles);
            end
            post_done = 1'b1;
        end
    end

    // Drive one start pulse; optionally push the expected result
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input bit push, input exp_t e);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        op_div   = op;
        start    = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] eq, input logic [31:0] er, input logic sa,
                       input logic sb, input logic [31:0] c2, input int bc);
        exp_t e;
        e.q = eq; e.r = er; e.sa = sa; e.sb = sb; e.c2 = c2; e.op = op; e.busy_cycles = bc;
        issue(a, b, op, 1'b1, e);
        wait_drain();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q"}, q, 32'd0);
        chk({tag, "_r"}, r, 32'd0);
        chk({tag, "_flags"}, {30'd0, dividend32, divisor32}, 32'd0);
        chk({tag, "_2c"}, divisor_2c, 32'd0);
        chk({tag, "_op"}, {30'd0, op_div_out}, 32'd0);
        chk({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        exp_t dummy;
        dummy.q = '0; dummy.r = '0; dummy.c2 = '0; dummy.sa = 0; dummy.sb = 0;
        dummy.op = '0; dummy.busy_cycles = 0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        //   a             b             op     q             r             sa sb 2c           busy
        run(32'd100,      32'd7,        2'b00, 32'd14,       32'd2,        0, 0, 32'hFFFFFFF9, FullBusy);
        // Outputs hold after done
        repeat (3) @(negedge clk);
        chk("hold_q", q, 32'd14);
        chk("hold_r", r, 32'd2);
        run(32'hFFFFFF9C, 32'd7,        2'b01, 32'd14,       32'd2,        1, 0, 32'hFFFFFFF9, FullBusy);
        run(32'd100,      32'hFFFFFFF9, 2'b01, 32'd14,       32'd2,        0, 1, 32'hFFFFFFF9, FullBusy);
        run(32'h80000000, 32'hFFFFFFFF, 2'b11, 32'h80000000, 32'd0,        1, 1, 32'hFFFFFFFF, FullBusy);
        run(32'h00001234, 32'd0,        2'b00, 32'hFFFFFFFF, 32'h00001234, 0, 0, 32'd0,        1);
        run(32'hFFFFFFFB, 32'd0,        2'b01, 32'hFFFFFFFF, 32'hFFFFFFFB, 0, 0, 32'd0,        1);
        run(32'hFFFFFFFF, 32'h80000001, 2'b00, 32'd1,        32'h7FFFFFFE, 0, 0, 32'h7FFFFFFF, FullBusy);
        run(32'd7,        32'd7,        2'b10, 32'd1,        32'd0,        0, 0, 32'hFFFFFFF9, FullBusy);
        run(32'd3,        32'd10,       2'b00, 32'd0,        32'd3,        0, 0, 32'hFFFFFFF6, EarlyBusy);
        run(32'd3,        32'hFFFFFFF6, 2'b01, 32'd0,        32'd3,        0, 1, 32'hFFFFFFF6, EarlyBusy);

        // Start mid-run is ignored, then reset aborts the operation
        issue(32'd1000, 32'd10, 2'b00, 1'b0, dummy);   // accepted; cycle 1
        repeat (3) @(negedge clk);
        issue(32'd55, 32'd5, 2'b01, 1'b0, dummy);      // cycle 5 start, must be ignored
        repeat (3) @(negedge clk);
        chk("ignored_start_op", {30'd0, op_div_out}, 32'd0);
        chk("still_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_all_zero("midreset");
        repeat (40) @(negedge clk);
        run(32'd1000, 32'd10, 2'b00, 32'd100, 32'd0, 0, 0, 32'hFFFFFFF6, FullBusy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
